// File: rtl/cpu_perf_monitor_pkg.sv
// Shared definitions for the CPU performance monitor: FSM encoding and default event indices.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package cpu_perf_monitor_pkg;

  // Run-control states; encodings are visible on the state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_HUNG  = 3'd4
  } state_t;

  // Default bit positions of the core's event strobes.
  localparam int EV_RETIRE    = 0;
  localparam int EV_STALL     = 1;
  localparam int EV_FLUSH     = 2;
  localparam int EV_BRANCH    = 3;
  localparam int EV_HALT      = 4;
  localparam int EV_BAD_OP    = 5;
  localparam int EV_BAD_FUNCT = 6;

  // Counting is only enabled while the core is running or draining after HALT.
  function automatic logic in_window(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/cpu_perf_monitor_mon_counter.sv
// One performance counter with clear, increment and either saturation or wrap with a sticky overflow flag.
// Latency: count updates one cycle after inc/clear.
// Backpressure: none; inc is accepted every cycle.
module mon_counter #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic                 w_at_max;

  assign w_at_max = &r_count;
  assign count    = r_count;
  assign ovf      = r_ovf;

  // Reset beats clear, clear beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      if (w_at_max) begin
        if (!SATURATE) begin
          r_count <= '0;
          r_ovf   <= 1'b1;
        end
      end else begin
        r_count <= r_count + ONE;
      end
    end
  end

endmodule

// File: rtl/cpu_perf_monitor.sv
// Run-control FSM, retire watchdog and event counters for the pipelined CPU, with a registered read port.
// Latency: counters update one cycle after the event; read data is valid one cycle after rd_en.
// Backpressure: none; events and reads are accepted every cycle, back-to-back reads included.
module cpu_perf_monitor
  import cpu_perf_monitor_pkg::*;
#(
  parameter int NUM_EVENTS   = 8,
  parameter int CNT_WIDTH    = 32,
  parameter bit SATURATE     = 1'b1,
  parameter int HALT_EVENT   = EV_HALT,
  parameter int RETIRE_EVENT = EV_RETIRE,
  parameter int DRAIN_CYCLES = 4,
  parameter int WATCHDOG     = 256,
  parameter int SEL_W        = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [NUM_EVENTS:0]   overflow,
  output logic [2:0]            state,
  output logic                  done,
  output logic                  hung
);

  localparam int WD_W = $clog2(WATCHDOG + 1);
  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(WATCHDOG);
  localparam logic [WD_W-1:0]  WD_ONE     = WD_W'(1);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [DR_W-1:0]  DR_ONE     = DR_W'(1);
  localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(NUM_EVENTS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WD_W-1:0]       r_wdog;
  logic [WD_W-1:0]       w_wdog_inc;
  logic [DR_W-1:0]       r_drain;
  logic                  w_window;
  logic                  w_halt;
  logic                  w_retire;
  logic                  w_wdog_hit;
  logic [NUM_EVENTS:0]   w_inc;
  logic [NUM_EVENTS:0]   w_ovf;
  logic [CNT_WIDTH-1:0]  w_cnt [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_err;

  assign w_window   = in_window(r_state);
  assign w_halt     = event_i[HALT_EVENT];
  assign w_retire   = event_i[RETIRE_EVENT];
  assign w_wdog_inc = r_wdog + WD_ONE;
  // A retire in the limit cycle restarts the watchdog instead of tripping it.
  assign w_wdog_hit = !w_retire && (w_wdog_inc == WD_LIMIT);

  assign state    = r_state;
  assign done     = (r_state == ST_DONE);
  assign hung     = (r_state == ST_HUNG);
  assign overflow = w_ovf;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; HALT is checked before the watchdog so a same-cycle collision drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_halt)          w_state_nxt = ST_DRAIN;
        else if (w_wdog_hit) w_state_nxt = ST_HUNG;
      end
      ST_DRAIN: if (r_drain == DRAIN_LAST) w_state_nxt = ST_DONE;
      default:  w_state_nxt = r_state;
    endcase
  end

  // Watchdog: held at zero outside RUN so it is fresh on entry, restarted by every retire.
  always_ff @(posedge clock) begin
    if (!reset)                 r_wdog <= '0;
    else if (r_state != ST_RUN) r_wdog <= '0;
    else if (w_retire)          r_wdog <= '0;
    else                        r_wdog <= w_wdog_inc;
  end

  // Drain timer: counts cycles spent in DRAIN, zero elsewhere.
  always_ff @(posedge clock) begin
    if (!reset)                   r_drain <= '0;
    else if (r_state != ST_DRAIN) r_drain <= '0;
    else                          r_drain <= r_drain + DR_ONE;
  end

  // Counter bank: one per event, plus the cycle counter in the top slot.
  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
    if (g < NUM_EVENTS) begin : g_ev
      assign w_inc[g] = w_window & event_i[g];
    end else begin : g_cyc
      assign w_inc[g] = w_window;
    end
    mon_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .inc   (w_inc[g]),
      .count (w_cnt[g]),
      .ovf   (w_ovf[g])
    );
  end

  // Registered read port; data holds between reads, valid/err are single-cycle pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      if (rd_en) begin
        if (rd_sel <= SEL_MAX) begin
          r_rd_data  <= w_cnt[rd_sel];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_data  <= '0;
          r_rd_err   <= 1'b1;
        end
      end
    end
  end

endmodule
